debounce_edge_counter: RTL
==========================

Name: debounce_edge_counter

Overview:
- Sits directly downstream of the two-flop input synchronizer and consumes its synchronized output.
- Debounces that level over a programmable number of consecutive clock samples.
- Emits single-cycle rise/fall strobes and keeps a running count of debounced rising events with a sticky overflow flag.
- Feeds control logic that must never see chatter or metastable edges.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a level change; legal range >= 2.
- CNT_WIDTH, 8, width of event_count.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- n_rst  input  1  reset, synchronous, active-high (1 = reset), sampled on rising clk edge.
- sync_in  input  1  synchronized level from the upstream synchronizer.
- clear  input  1  synchronous clear of event_count and count_overflow.
- level_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle strobe on accepted low->high change.
- fall_pulse  output  1  one-cycle strobe on accepted high->low change.
- event_count  output  CNT_WIDTH  number of accepted rising events, modulo 2^CNT_WIDTH.
- count_overflow  output  1  sticky flag: event_count wrapped at least once since reset or clear.

Behaviour:
- Reset (n_rst=1 at an edge): state=STABLE_LOW, timer=0, level_out=0, rise_pulse=0, fall_pulse=0, event_count=0, count_overflow=0. Reset overrides all other inputs, including clear.
- All outputs are registered. No combinational path from input to output.
- State machine: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW. The timer is $clog2(DEBOUNCE_CYCLES)+1 bits.
- STABLE_LOW: sync_in=1 -> PEND_HIGH, timer=1. Otherwise stay.
- PEND_HIGH: sync_in=0 -> STABLE_LOW, timer=0 (glitch rejected, no pulse).
- PEND_HIGH: sync_in=1 and timer==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, timer=0, level_out<=1, rise_pulse<=1.
- PEND_HIGH: otherwise timer++.
- STABLE_HIGH and PEND_LOW mirror the above with polarity inverted. Acceptance sets level_out<=0 and fall_pulse<=1.
- Latency: if edge k is the first edge sampling the new value and the value is held, level_out and the strobe change after edge k+DEBOUNCE_CYCLES-1. That is, DEBOUNCE_CYCLES consecutive samples are required.
- Strobes are high for exactly one cycle. rise_pulse and fall_pulse are never high together.
- Minimum spacing between a rise_pulse and the next fall_pulse is DEBOUNCE_CYCLES cycles.
- Counting: event_count increments by 1 at the same edge that sets rise_pulse. Falling events are not counted.
- Wrap: incrementing from 2^CNT_WIDTH-1 gives 0 and sets count_overflow=1. count_overflow stays set until reset or clear.
- clear=1 at an edge: event_count=0, count_overflow=0. clear has priority over a simultaneous increment, so that event is not counted, but rise_pulse still fires.
- clear does not affect the debounce state, timer, level_out or the strobes.
- Reset mid-pending aborts the pending change; no strobe is issued.
- sync_in held high through reset release needs a full DEBOUNCE_CYCLES samples after release before rise_pulse fires.

Decomposition:
- Package debounce_pkg: typedef enum logic [1:0] debounce_state_t {STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW}.
- Sub-module edge_event_counter (parameter CNT_WIDTH): wrapping counter with inputs clk, n_rst, clear, inc and outputs count, overflow.
- The top level holds the FSM, timer and strobe registers, and instantiates edge_event_counter driven by the next-cycle rise strobe.

Test Plan:
- Test parameters: DEBOUNCE_CYCLES=4, CNT_WIDTH=4 throughout.
- Glitch rejection: from reset, sync_in=1 for 3 cycles then 0 -> level_out stays 0, no rise_pulse, event_count=0.
- Clean rise and fall: sync_in=1 held from edge k -> level_out=1 and rise_pulse=1 for exactly one cycle after edge k+3, event_count=1. Then sync_in=0 held from edge m -> fall_pulse one cycle after edge m+3, level_out=0, event_count still 1.
- Wrap: 16 clean rise/fall cycles -> event_count reads 15 after the 15th rise and 0 after the 16th, with count_overflow=1; the 17th rise gives event_count=1 and count_overflow still 1.
- Clear collision: assert clear on the same edge that accepts a rise with event_count=5 -> event_count=0, count_overflow=0, rise_pulse=1, level_out=1.
- Reset mid-operation: sync_in=1 for 2 cycles, then n_rst=1 for 1 cycle with sync_in still 1 -> all outputs 0 after reset; rise_pulse occurs only after 4 further consecutive high samples.
- Chatter on high: in STABLE_HIGH, toggle sync_in 1-0-1 repeatedly with low runs shorter than 4 cycles -> level_out stays 1 and fall_pulse is never asserted.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared debounce FSM state encoding.
package debounce_pkg;
  typedef enum logic [1:0] {
    STABLE_LOW,
    PEND_HIGH,
    STABLE_HIGH,
    PEND_LOW
  } debounce_state_t;
endpackage

// File: rtl/edge_event_counter.sv
// edge_event_counter: wrapping event counter with sticky overflow and synchronous clear.
module edge_event_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);
  always_ff @(posedge clk) begin
    if (n_rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc) begin
      count    <= count + CNT_WIDTH'(1);
      overflow <= overflow | (&count);
    end
  end
endmodule

// File: rtl/debounce_edge_counter.sv
// debounce_edge_counter: debounces a synchronized level, emits edge strobes and counts rising events.
module debounce_edge_counter
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sync_in,
  input  logic                 clear,
  output logic                 level_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic                 count_overflow
);
  localparam int TW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(DEBOUNCE_CYCLES - 1);
  debounce_state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic level_n, rise_n, fall_n;
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state      <= STABLE_LOW;
      timer      <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      level_out  <= level_n;
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
    end
  end
  always_comb begin
    state_n = state;
    timer_n = timer + TW'(1);
    level_n = level_out;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      STABLE_LOW: begin
        timer_n = sync_in ? TW'(1) : '0;
        state_n = sync_in ? PEND_HIGH : STABLE_LOW;
      end
      PEND_HIGH: begin
        if (!sync_in) begin
          state_n = STABLE_LOW;
          timer_n = '0;
        end else if (timer == T_LAST) begin
          state_n = STABLE_HIGH;
          timer_n = '0;
          level_n = 1'b1;
          rise_n  = 1'b1;
        end
      end
      STABLE_HIGH: begin
        timer_n = !sync_in ? TW'(1) : '0;
        state_n = !sync_in ? PEND_LOW : STABLE_HIGH;
      end
      PEND_LOW: begin
        if (sync_in) begin
          state_n = STABLE_HIGH;
          timer_n = '0;
        end else if (timer == T_LAST) begin
          state_n = STABLE_LOW;
          timer_n = '0;
          level_n = 1'b0;
          fall_n  = 1'b1;
        end
      end
      default: begin
        state_n = STABLE_LOW;
        timer_n = '0;
      end
    endcase
  end
  // Counter advances on the same edge that raises rise_pulse
  edge_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (clear),
    .inc      (rise_n),
    .count    (event_count),
    .overflow (count_overflow)
  );
endmodule
